// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic {RUN, MUL_BUSY} state_t;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// fwd_sel: picks the ALU operand source for one EX source index.
// EX/MEM is the younger result, so it wins over MEM/WB.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output fwd_sel_t   sel
);
    always_comb begin
        sel = (src == XZR) ? FWD_RF :
              (mem_regwrite && mem_rd == src) ? FWD_MEM :
              (wb_regwrite && wb_rd == src) ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush, multiply sequencing and forwarding for the 5-stage pipe.
// Define HAZARD_PERF_EN to add the saturating stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_is_mul,
    input  logic [4:0]       ex_rn,
    input  logic [4:0]       ex_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             rf_bypass_a,
    output logic             rf_bypass_b,
    output logic             busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] mcnt_q, mcnt_d;
    logic       run, load_use;
    fwd_sel_t   sel_a, sel_b;

    fwd_sel u_fwd_a (
        .src(ex_rn), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
    );
    fwd_sel u_fwd_b (
        .src(ex_rm), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
    );

    always_comb begin
        run      = (state_q == RUN);
        load_use = id_valid && ex_memread && ex_regwrite && ex_rd != XZR &&
                   ((id_use_rn && ex_rd == id_rn) || (id_use_rm && ex_rd == id_rm));
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        if (run) begin
            if (!ex_br_taken && !load_use && id_valid && id_is_mul) begin
                state_d = MUL_BUSY;
                mcnt_d  = MCNT_INIT;
            end
        end else begin
            mcnt_d = mcnt_q - 4'd1;
            if (mcnt_q == 4'd1)
                state_d = RUN;
        end
    end

    // Every control output is gated by rst_n so reset silences the pipe immediately.
    always_comb begin
        ifid_flush  = rst_n && run && ex_br_taken;
        idex_bubble = rst_n && run && (ex_br_taken || load_use);
        idex_hold   = rst_n && !run;
        pc_stall    = rst_n && (!run || (!ex_br_taken && load_use));
        ifid_stall  = pc_stall;
        busy        = rst_n && !run;
        fwd_a       = rst_n ? sel_a : FWD_RF;
        fwd_b       = rst_n ? sel_b : FWD_RF;
        rf_bypass_a = rst_n && wb_regwrite && id_use_rn && id_rn != XZR && wb_rd == id_rn;
        rf_bypass_b = rst_n && wb_regwrite && id_use_rm && id_rm != XZR && wb_rd == id_rm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            mcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = (pc_stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (ifid_flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scenario tasks push expected output vectors, sampled and compared each negedge.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rn, id_use_rm, id_is_mul;
    logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, ex_br_taken;
    logic pc_stall, ifid_stall, idex_bubble, idex_hold, ifid_flush;
    logic [1:0] fwd_a, fwd_b;
    logic rf_bypass_a, rf_bypass_b, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_is_mul(id_is_mul),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .idex_hold(idex_hold), .ifid_flush(ifid_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .rf_bypass_a(rf_bypass_a), .rf_bypass_b(rf_bypass_b), .busy(busy)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifndef HAZARD_PERF_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // Vector order: pc_stall, ifid_stall, bubble, hold, flush, busy, fwd_a, fwd_b, byp_a, byp_b
    function automatic logic [11:0] ev(logic ps, logic bub, logic hold, logic fl, logic bsy,
                                       logic [1:0] fa, logic [1:0] fb, logic ba, logic bb);
        return {ps, ps, bub, hold, fl, bsy, fa, fb, ba, bb};
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_use_rn = 0; id_use_rm = 0; id_is_mul = 0;
        id_rn = 0; id_rm = 0; ex_rn = 0; ex_rm = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_regwrite = 0; wb_regwrite = 0; ex_br_taken = 0;
    endtask

    // Inputs are set just after a posedge; outputs are sampled at the following negedge.
    task automatic cycle(string name, logic [11:0] e);
        logic [11:0] got, want;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        got = {pc_stall, ifid_stall, idex_bubble, idex_hold, ifid_flush, busy,
               fwd_a, fwd_b, rf_bypass_a, rf_bypass_b};
        if (!rst_n) begin
            m_stall = 0;
            m_flush = 0;
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
            errors++;
            $display("FAIL %s_cnt: stall %0d flush %0d expected %0d %0d",
                     name, stall_cnt, flush_cnt, m_stall, m_flush);
        end
`endif
        m_stall += int'(want[11]);
        m_flush += int'(want[7]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        id_valid = 1; id_rn = 3; id_use_rn = 1; ex_rd = 3; ex_memread = 1; ex_regwrite = 1;
        ex_br_taken = 1; mem_rd = 4; mem_regwrite = 1; ex_rn = 4;
        wb_rd = 3; wb_regwrite = 1;
        @(posedge clk);
        #1;
        cycle("reset_outputs", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
        rst_n = 1;
        cycle("reset_release", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    endtask

    task automatic test_load_use();
        id_valid = 1; id_rn = 3; id_use_rn = 1;
        ex_rd = 3; ex_memread = 1; ex_regwrite = 1;
        cycle("load_use_rn", ev(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
        mem_rd = 3; mem_regwrite = 1; ex_rn = 3;
        cycle("load_use_fwd", ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        clear_inputs();
        id_valid = 1; id_rm = 7; id_use_rm = 1; ex_rd = 7; ex_memread = 1; ex_regwrite = 1;
        cycle("load_use_rm", ev(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_use_rm = 0;
        cycle("load_use_unused", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_use_rm = 1; id_valid = 0;
        cycle("load_use_invalid", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
    endtask

    task automatic test_mul();
        id_valid = 1; id_is_mul = 1;
        cycle("mul_issue", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        ex_br_taken = 1;
        id_rn = 9; id_use_rn = 1; ex_rd = 9; ex_memread = 1; ex_regwrite = 1;
        for (int i = 0; i < 3; i++)
            cycle("mul_busy", ev(1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        clear_inputs();
        cycle("mul_done", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    endtask

    task automatic test_back_to_back();
        id_valid = 1; id_is_mul = 1;
        cycle("b2b_issue1", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        for (int i = 0; i < 3; i++)
            cycle("b2b_busy1", ev(1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        cycle("b2b_issue2", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_is_mul = 0;
        for (int i = 0; i < 3; i++)
            cycle("b2b_busy2", ev(1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0));
        cycle("b2b_done", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        id_valid = 1; id_rn = 3; id_use_rn = 1; ex_rd = 3; ex_memread = 1; ex_regwrite = 1;
        id_is_mul = 1; ex_br_taken = 1;
        cycle("br_over_lu_mul", ev(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0));
        ex_br_taken = 0; ex_memread = 0; id_is_mul = 0;
        cycle("br_no_mul_state", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_is_mul = 1; ex_memread = 1;
        cycle("lu_over_mul", ev(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
        cycle("lu_no_mul_state", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    endtask

    task automatic test_xzr();
        id_valid = 1; id_rn = 31; id_use_rn = 1; id_rm = 31; id_use_rm = 1;
        ex_rd = 31; ex_memread = 1; ex_regwrite = 1;
        mem_rd = 31; mem_regwrite = 1; ex_rn = 31; ex_rm = 31;
        wb_rd = 31; wb_regwrite = 1;
        cycle("xzr_all", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        clear_inputs();
    endtask

    task automatic test_double_hazard();
        mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
        ex_rm = 5; ex_rn = 5; id_rm = 5; id_use_rm = 1; id_rn = 5;
        cycle("double_mem_wins", ev(0, 0, 0, 0, 0, 2'b10, 2'b10, 0, 1));
        mem_regwrite = 0; id_use_rn = 1;
        cycle("double_wb_only", ev(0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 1));
        wb_regwrite = 0; mem_regwrite = 1; ex_rn = 6; mem_rd = 6;
        cycle("mem_only_a", ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        clear_inputs();
    endtask

    task automatic test_reset_mid_mul();
        id_valid = 1; id_is_mul = 1;
        cycle("rst_mul_issue", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        id_is_mul = 0;
        ex_rn = 8; mem_rd = 8; mem_regwrite = 1;
        cycle("rst_mul_busy1", ev(1, 0, 1, 0, 1, 2'b10, 2'b00, 0, 0));
        rst_n = 0;
        cycle("rst_mul_busy2", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        rst_n = 1;
        clear_inputs();
        cycle("rst_mul_after", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        cycle("rst_mul_after2", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_simultaneous();
        test_xzr();
        test_double_hazard();
        test_reset_mid_mul();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t limit 100000", $time);
        $fatal(1);
    end
endmodule
